prog_freq_div: RTL and testbench

Parametrised, runtime-programmable successor to the fixed divide-by-50 clock divider. It divides clkin by a loadable divisor N and drives either a duty-balanced divided clock (toggle mode) or a one-cycle enable strobe (pulse mode). Divisor and mode updates are shadowed and take effect only at a period boundary, so clkout never glitches. It feeds counter and display-scan logic that needs several slow rates from one board clock.

---
 rtl/prog_freq_div_pkg.sv | 19 +
 rtl/prog_freq_div.sv | 129 ++++++++++++
 tb/tb_prog_freq_div.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_freq_div_pkg.sv
// Shared definitions for the programmable frequency divider.
package prog_freq_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Divisors below 2 cannot produce a valid period, so they are raised to 2.
    // Operates on a 32-bit container; callers cast to their own width.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        logic [31:0] r;
        if (d < 32'd2) begin
            r = 32'd2;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_freq_div.sv
// Runtime-programmable clock divider with toggle (balanced clock) and pulse
// (one-cycle strobe) outputs. Divisor/mode changes are shadowed and only
// become active at a period boundary or on restart, so clkout never glitches.
// WIDTH is limited to 32 by the package clamp helper.
module prog_freq_div
    import prog_freq_div_pkg::*;
#(
    parameter int   WIDTH        = 8,
    parameter int   DEFAULT_DIV  = 50,
    parameter logic DEFAULT_MODE = 1'b0
) (
    input  logic             clkin,
    input  logic             clr,
    input  logic             en,
    input  logic             restart,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    input  logic             div_load,
    output logic             clkout,
    output logic             tick,
    output logic             upd_pending
);

    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(0);
    localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] div_r;
    logic             mode_r;
    logic [WIDTH-1:0] shadow_div_r;
    logic             shadow_mode_r;
    logic             pend_r;
    logic             clkout_r;
    logic             tick_r;

    logic             wrap_s;
    logic             apply_s;
    logic [WIDTH-1:0] act_div_s;
    logic             act_mode_s;
    logic [WIDTH-1:0] cnt_next_s;
    logic [WIDTH:0]   half_s;
    logic             toggle_hi_s;

    // Wrap detection, boundary/restart apply decision and next-state values.
    // The active divisor/mode seen by this edge is the post-apply one.
    always_comb begin
        wrap_s      = (cnt_r == (div_r - ONE_W));
        apply_s     = 1'b0;
        act_div_s   = div_r;
        act_mode_s  = mode_r;
        cnt_next_s  = ZERO_W;
        half_s      = {(WIDTH+1){1'b0}};
        toggle_hi_s = 1'b0;

        if (restart) begin
            apply_s = pend_r;
        end else if (en) begin
            apply_s = wrap_s & pend_r;
        end else begin
            apply_s = 1'b0;
        end

        if (apply_s) begin
            act_div_s  = WIDTH'(clamp_div(32'(shadow_div_r)));
            act_mode_s = shadow_mode_r;
        end else begin
            act_div_s  = div_r;
            act_mode_s = mode_r;
        end

        if (wrap_s) begin
            cnt_next_s = ZERO_W;
        end else begin
            cnt_next_s = cnt_r + ONE_W;
        end

        // One extra bit so that (N+1) cannot overflow when N = 2^WIDTH-1.
        half_s      = ({1'b0, act_div_s} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        toggle_hi_s = ({1'b0, cnt_next_s} < half_s);
    end

    // Counter, active configuration, shadow registers and registered outputs.
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            cnt_r         <= ZERO_W;
            div_r         <= DEF_W;
            mode_r        <= DEFAULT_MODE;
            shadow_div_r  <= ZERO_W;
            shadow_mode_r <= 1'b0;
            pend_r        <= 1'b0;
            clkout_r      <= 1'b0;
            tick_r        <= 1'b0;
        end else begin
            div_r  <= act_div_s;
            mode_r <= act_mode_s;

            if (restart) begin
                cnt_r    <= ZERO_W;
                tick_r   <= 1'b0;
                clkout_r <= (act_mode_s == MODE_PULSE) ? 1'b0 : 1'b1;
            end else if (en) begin
                cnt_r    <= cnt_next_s;
                tick_r   <= wrap_s;
                clkout_r <= (act_mode_s == MODE_PULSE) ? wrap_s : toggle_hi_s;
            end else begin
                cnt_r    <= cnt_r;
                tick_r   <= tick_r;
                clkout_r <= clkout_r;
            end

            // A load in the same cycle as an apply is captured after it.
            if (div_load) begin
                shadow_div_r  <= div_in;
                shadow_mode_r <= mode_in;
                pend_r        <= 1'b1;
            end else if (apply_s) begin
                pend_r        <= 1'b0;
            end else begin
                pend_r        <= pend_r;
            end
        end
    end

    assign clkout      = clkout_r;
    assign tick        = tick_r;
    assign upd_pending = pend_r;

endmodule

// File: tb/tb_prog_freq_div.sv
// Self-checking bench for prog_freq_div: a hand-derived vector table,
// a behavioural reference model feeding a scoreboard queue, and a few
// directed multi-cycle sequences (period measurement, async clear).
module tb_prog_freq_div;

    logic       clkin = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       mode_in = 1'b0;
    logic       div_load = 1'b0;
    logic       clkout;
    logic       tick;
    logic       upd_pending;

    prog_freq_div #(.WIDTH(8), .DEFAULT_DIV(50), .DEFAULT_MODE(1'b0)) dut (
        .clkin(clkin), .clr(clr), .en(en), .restart(restart),
        .div_in(div_in), .mode_in(mode_in), .div_load(div_load),
        .clkout(clkout), .tick(tick), .upd_pending(upd_pending)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        bit c;
        bit t;
        bit p;
    } exp_t;

    typedef struct {
        bit en;
        bit rs;
        bit ld;
        int div;
        bit md;
        bit e_c;
        bit e_t;
        bit e_p;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    string phase = "init";

    // reference model state
    int m_cnt, m_n, m_sdiv;
    bit m_mode, m_smode, m_pend, m_clk, m_tick;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_n = 50; m_mode = 1'b0; m_sdiv = 0; m_smode = 1'b0;
        m_pend = 1'b0; m_clk = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit rs, input bit ld, input int d, input bit md);
        bit wrap;
        bit ap;
        wrap = (m_cnt == m_n - 1);
        ap = rs ? m_pend : (e && wrap && m_pend);
        if (ap) begin
            m_n    = (m_sdiv < 2) ? 2 : m_sdiv;
            m_mode = m_smode;
        end
        if (rs) begin
            m_cnt  = 0;
            m_tick = 1'b0;
            m_clk  = m_mode ? 1'b0 : 1'b1;
        end else if (e) begin
            m_cnt  = wrap ? 0 : m_cnt + 1;
            m_tick = wrap;
            m_clk  = m_mode ? wrap : (m_cnt < (m_n + 1) / 2);
        end
        if (ld) begin
            m_sdiv = d; m_smode = md; m_pend = 1'b1;
        end else if (ap) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            chk("clkout", int'(clkout), int'(x.c));
            chk("tick", int'(tick), int'(x.t));
            chk("upd_pending", int'(upd_pending), int'(x.p));
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, compare after the edge.
    task automatic step(input bit e, input bit rs, input bit ld, input int d, input bit md,
                        input bit use_tab, input exp_t te);
        exp_t x;
        en = e; restart = rs; div_load = ld; div_in = 8'(d); mode_in = md;
        model_edge(e, rs, ld, d, md);
        if (use_tab) x = te;
        else begin
            x.c = m_clk; x.t = m_tick; x.p = m_pend;
        end
        sb.push_back(x);
        @(posedge clkin);
        #1;
        check_out();
        en = 1'b0; restart = 1'b0; div_load = 1'b0;
    endtask

    task automatic run(input bit e, input int n);
        exp_t z;
        z = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, 0, 1'b0, 1'b0, z);
    endtask

    task automatic load(input int d, input bit md);
        exp_t z;
        z = '{1'b0, 1'b0, 1'b0};
        step(1'b1, 1'b0, 1'b1, d, md, 1'b0, z);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        model_reset();
        @(posedge clkin);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[15];
        exp_t z;
        int last;
        int hi;
        z = '{1'b0, 1'b0, 1'b0};

        // Hand-derived sequence starting from reset (N=50 toggle, cnt=0).
        //            en    rs    ld   div  md    clk   tick  pend
        tab[0]  = '{1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[1]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[3]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[4]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[5]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[6]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[7]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[8]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[10] = '{1'b1, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[11] = '{1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b1, 1'b1};
        tab[12] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[13] = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[14] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};

        model_reset();
        repeat (2) @(posedge clkin);
        #1;
        clr = 1'b0;

        phase = "reset";
        chk("clkout", int'(clkout), 0);
        chk("tick", int'(tick), 0);
        chk("upd_pending", int'(upd_pending), 0);

        phase = "table";
        for (int i = 0; i < 15; i++) begin
            exp_t te;
            te.c = tab[i].e_c; te.t = tab[i].e_t; te.p = tab[i].e_p;
            step(tab[i].en, tab[i].rs, tab[i].ld, tab[i].div, tab[i].md, 1'b1, te);
        end

        // Default divide-by-50: measure period and high time directly.
        phase = "n50";
        do_clr();
        last = -1;
        hi = 0;
        for (int i = 0; i < 160; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, z);
            if (tick === 1'b1) begin
                chk("tick_with_rise", int'(clkout), 1);
                if (last >= 0) begin
                    chk("period", i - last, 50);
                    chk("high_cycles", hi, 25);
                end
                last = i;
                hi = 0;
            end
            if (clkout === 1'b1) hi++;
        end
        chk("ticks_seen", int'(last >= 0), 1);

        phase = "n4_toggle";
        run(1'b1, 20);
        load(4, 1'b0);
        run(1'b1, 50);

        phase = "n5_pulse";
        load(5, 1'b1);
        run(1'b1, 30);

        phase = "n0_clamp";
        load(0, 1'b1);
        run(1'b1, 20);

        phase = "n7_freeze";
        load(7, 1'b0);
        run(1'b1, 16);
        run(1'b0, 10);
        run(1'b1, 21);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 12)),
                 1'($urandom_range(0, 1)), 1'b0, z);
        end

        // Asynchronous clear mid-period with an update pending.
        phase = "async_clr";
        do_clr();
        run(1'b1, 5);
        load(20, 1'b1);
        chk("pre_clkout", int'(clkout), 1);
        chk("pre_pending", int'(upd_pending), 1);
        #3;
        clr = 1'b1;
        #1;
        chk("clkout", int'(clkout), 0);
        chk("tick", int'(tick), 0);
        chk("upd_pending", int'(upd_pending), 0);
        model_reset();
        @(posedge clkin);
        #1;
        clr = 1'b0;
        phase = "after_clr";
        run(1'b1, 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
